// File: rtl/io_ram_arbiter_pkg.sv
// Shared constants and types for the layer input/output RAM arbiter.
// Requester order is fixed: 0 network sequencer, 1 image loader, 2 result reader.
package io_ram_arbiter_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_NET   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_READ  = 2;
    localparam int IO_ADDR_W = 10;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef logic [IDX_W-1:0] req_idx_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/io_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the IO RAM arbiter.
// master = requesters plus RAM model, slave = the arbiter itself.
interface io_ram_arbiter_if;
    import io_ram_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                wren;
    logic [NUM_REQ-1:0][IO_ADDR_W-1:0] address;
    logic [NUM_REQ-1:0][DATA_W-1:0]    d;
    logic [NUM_REQ-1:0]                gnt;
    logic [NUM_REQ-1:0]                rd_valid;
    logic [DATA_W-1:0]                 q;

    logic                              ram_wren;
    logic [IO_ADDR_W-1:0]              ram_address;
    logic [DATA_W-1:0]                 ram_d;
    logic [DATA_W-1:0]                 ram_q;

    modport master (
        output req, wren, address, d, ram_q,
        input  gnt, rd_valid, q, ram_wren, ram_address, ram_d
    );

    modport slave (
        input  req, wren, address, d, ram_q,
        output gnt, rd_valid, q, ram_wren, ram_address, ram_d
    );

endinterface

// File: rtl/io_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req set,
// searching upward from last+1 and wrapping.
module io_ram_arbiter_rr_pick
    import io_ram_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output req_idx_t           winner,
    output logic               any_valid
);

    req_idx_t           cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[k] is the requester visited k-th in round-robin order after last
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = req_idx_t'((int'(last) + gi + 1) % NUM_REQ);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner    = cand[k];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_ram_arbiter.sv
// Whole-burst round-robin arbiter for the single port of the layer IO RAM.
// Grants are registered; the RAM port is a combinational mux of the owner's inputs.
module io_ram_arbiter
    import io_ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 0
) (
    input  logic             clk,
    input  logic             rst,
    io_ram_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX =
        (MAX_BURST > 0) ? HOLD_W'(MAX_BURST - 1) : HOLD_W'(0);

    arb_state_t          state_q, state_d;
    req_idx_t            owner_q, owner_d;
    req_idx_t            last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;

    logic [NUM_REQ-1:0]  pick_req;
    req_idx_t            pick_last;
    req_idx_t            winner;
    logic                any_valid;
    logic                forced;
    logic                owner_done;
    logic [NUM_REQ-1:0]  acc;

    // While owning, the current owner is masked out so any hit is "another pending"
    assign pick_req  = (state_q == OWN) ? (bus.req & ~idx_onehot(owner_q)) : bus.req;
    assign pick_last = (state_q == OWN) ? owner_q : last_q;

    io_ram_arbiter_rr_pick u_rr_pick (
        .req       (pick_req),
        .last      (pick_last),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign forced     = (MAX_BURST > 0) && (hold_q == HOLD_MAX) && any_valid;
    assign owner_done = !bus.req[owner_q] || forced;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = OWN;
                    owner_d = winner;
                    gnt_d   = idx_onehot(winner);
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (owner_done) begin
                    last_d = owner_q;
                    hold_d = '0;
                    if (any_valid) begin
                        owner_d = winner;
                        gnt_d   = idx_onehot(winner);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    // Saturates so a late arrival still preempts a long lone burst
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_acc
        assign acc[gi] = gnt_q[gi] & bus.req[gi];
    end

    always_comb begin
        bus.ram_wren    = 1'b0;
        bus.ram_address = '0;
        bus.ram_d       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                bus.ram_wren    = bus.wren[i];
                bus.ram_address = bus.address[i];
                bus.ram_d       = bus.d[i];
            end
        end
    end

    // Read returns are tagged by the issuing requester, not the next owner
    assign rd_valid_d = acc & ~bus.wren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= req_idx_t'(NUM_REQ - 1);
            hold_q     <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.q        = bus.ram_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_io_ram_arbiter.sv
// Bench for io_ram_arbiter: one unlimited-burst and one MAX_BURST=4 instance
// share stimulus; directed scenarios plus a random run against a behavioural model.
module tb_io_ram_arbiter;
    import io_ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NUM_REQ-1:0]                req_s  = '0;
    logic [NUM_REQ-1:0]                wren_s = '0;
    logic [NUM_REQ-1:0][IO_ADDR_W-1:0] addr_s = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0]    d_s    = '0;

    logic [DATA_W-1:0] mem_f [1 << IO_ADDR_W];
    logic [DATA_W-1:0] mem_b [1 << IO_ADDR_W];

    int errors = 0;
    int checks = 0;

    io_ram_arbiter_if bus_f();
    io_ram_arbiter_if bus_b();

    io_ram_arbiter #(.MAX_BURST(0)) u_dut_free (.clk(clk), .rst(rst), .bus(bus_f.slave));
    io_ram_arbiter #(.MAX_BURST(4)) u_dut_burst (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    assign bus_f.req     = req_s;
    assign bus_f.wren    = wren_s;
    assign bus_f.address = addr_s;
    assign bus_f.d       = d_s;
    assign bus_b.req     = req_s;
    assign bus_b.wren    = wren_s;
    assign bus_b.address = addr_s;
    assign bus_b.d       = d_s;

    // Single-port RAM with one-cycle registered read, one per instance
    always @(posedge clk) begin
        if (bus_f.ram_wren) mem_f[bus_f.ram_address] <= bus_f.ram_d;
        bus_f.ram_q <= mem_f[bus_f.ram_address];
        if (bus_b.ram_wren) mem_b[bus_b.ram_address] <= bus_b.ram_d;
        bus_b.ram_q <= mem_b[bus_b.ram_address];
    end

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'(a * 37 + 4096);
    endfunction

    function automatic int rr_next(input logic [NUM_REQ-1:0] r, input int from, input int skip);
        for (int s = 1; s <= NUM_REQ; s++) begin
            int j;
            j = (from + s) % NUM_REQ;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_s  = '0;
        wren_s = '0;
        addr_s = '0;
        d_s    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        req_s     = 3'b111;
        wren_s    = 3'b111;
        addr_s[0] = 10'd44;
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt_free: got %b want 000", bus_f.gnt); end
        checks++; if (bus_b.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt_burst: got %b want 000", bus_b.gnt); end
        checks++; if (bus_f.rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rdvalid: got %b want 000", bus_f.rd_valid); end
        checks++; if (bus_f.ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b want 0", bus_f.ram_wren); end
        checks++; if (bus_f.ram_address !== '0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", bus_f.ram_address); end
        tick();
        clear_inputs();
        rst = 1'b0;
        $display("tb: test_reset done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_first_read();
        do_reset();
        req_s     = 3'b001;
        addr_s[0] = 10'd5;
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b000) begin errors++; $display("FAIL first_gnt_latency: got %b want 000", bus_f.gnt); end
        checks++; if (bus_f.ram_address !== 10'd0) begin errors++; $display("FAIL first_ungranted_addr: got %0d want 0", bus_f.ram_address); end
        tick();
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b001) begin errors++; $display("FAIL first_gnt: got %b want 001", bus_f.gnt); end
        checks++; if (bus_f.ram_address !== 10'd5) begin errors++; $display("FAIL first_addr: got %0d want 5", bus_f.ram_address); end
        checks++; if (bus_f.ram_wren !== 1'b0) begin errors++; $display("FAIL first_wren: got %b want 0", bus_f.ram_wren); end
        tick();
        req_s = 3'b000;
        @(negedge clk);
        checks++; if (bus_f.rd_valid !== 3'b001) begin errors++; $display("FAIL first_rdvalid: got %b want 001", bus_f.rd_valid); end
        checks++; if (bus_f.q !== init_val(5)) begin errors++; $display("FAIL first_q: got %h want %h", bus_f.q, init_val(5)); end
        tick();
        tick();
        $display("tb: test_first_read done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp;
        do_reset();
        req_s = 3'b111;
        tick();
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 4) req_s[k] = 1'b0;
                exp    = '0;
                exp[k] = 1'b1;
                @(negedge clk);
                checks++;
                if (bus_f.gnt !== exp) begin
                    errors++;
                    $display("FAIL b2b_gnt owner %0d cyc %0d: got %b want %b", k, c, bus_f.gnt, exp);
                end
                tick();
            end
        end
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b000) begin errors++; $display("FAIL b2b_final_idle: got %b want 000", bus_f.gnt); end
        tick();
        $display("tb: test_back_to_back done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_loader_write();
        do_reset();
        req_s     = 3'b010;
        wren_s    = 3'b010;
        addr_s[1] = 10'd20;
        d_s[1]    = 16'h00FF;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                req_s[2]  = 1'b1;
                wren_s[2] = 1'b1;
                addr_s[2] = 10'd33;
                d_s[2]    = 16'hBEEF;
            end
            @(negedge clk);
            checks++; if (bus_f.gnt !== 3'b010) begin errors++; $display("FAIL load_gnt cyc %0d: got %b want 010", c, bus_f.gnt); end
            checks++;
            if (bus_f.ram_address !== 10'd20 || bus_f.ram_d !== 16'h00FF || bus_f.ram_wren !== 1'b1) begin
                errors++;
                $display("FAIL load_port cyc %0d: got addr %0d d %h we %b want addr 20 d 00ff we 1",
                         c, bus_f.ram_address, bus_f.ram_d, bus_f.ram_wren);
            end
            tick();
        end
        req_s[1]  = 1'b0;
        wren_s[1] = 1'b0;
        @(negedge clk);
        checks++; if (bus_f.ram_wren !== 1'b0) begin errors++; $display("FAIL load_drop_wren: got %b want 0", bus_f.ram_wren); end
        tick();
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b100) begin errors++; $display("FAIL load_handoff_gnt: got %b want 100", bus_f.gnt); end
        checks++; if (bus_f.ram_address !== 10'd33) begin errors++; $display("FAIL load_reader_addr: got %0d want 33", bus_f.ram_address); end
        checks++; if (mem_f[20] !== 16'h00FF) begin errors++; $display("FAIL load_ram20: got %h want 00ff", mem_f[20]); end
        clear_inputs();
        tick();
        tick();
        $display("tb: test_loader_write done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_read_tag();
        do_reset();
        req_s     = 3'b101;
        addr_s[0] = 10'd9;
        addr_s[2] = 10'd12;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus_b.gnt !== 3'b001) begin errors++; $display("FAIL tag_gnt cyc %0d: got %b want 001", c, bus_b.gnt); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus_b.gnt !== 3'b100) begin errors++; $display("FAIL tag_handoff_gnt: got %b want 100", bus_b.gnt); end
        checks++; if (bus_b.rd_valid !== 3'b001) begin errors++; $display("FAIL tag_rdvalid: got %b want 001", bus_b.rd_valid); end
        checks++; if (bus_b.q !== init_val(9)) begin errors++; $display("FAIL tag_q: got %h want %h", bus_b.q, init_val(9)); end
        checks++; if (bus_f.gnt !== 3'b001) begin errors++; $display("FAIL tag_free_keeps: got %b want 001", bus_f.gnt); end
        tick();
        @(negedge clk);
        checks++; if (bus_b.rd_valid !== 3'b100) begin errors++; $display("FAIL tag_reader_rdvalid: got %b want 100", bus_b.rd_valid); end
        checks++; if (bus_b.q !== init_val(12)) begin errors++; $display("FAIL tag_reader_q: got %h want %h", bus_b.q, init_val(12)); end
        clear_inputs();
        tick();
        tick();
        $display("tb: test_read_tag done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_max_burst();
        logic [NUM_REQ-1:0] exp_b [8] = '{3'b001, 3'b001, 3'b001, 3'b001,
                                          3'b010, 3'b010, 3'b010, 3'b001};
        do_reset();
        req_s = 3'b001;
        tick();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) req_s[1] = 1'b1;
            if (c == 6) req_s[1] = 1'b0;
            @(negedge clk);
            checks++; if (bus_b.gnt !== exp_b[c]) begin errors++; $display("FAIL burst_gnt cyc %0d: got %b want %b", c, bus_b.gnt, exp_b[c]); end
            checks++; if (bus_f.gnt !== 3'b001) begin errors++; $display("FAIL burst_free_gnt cyc %0d: got %b want 001", c, bus_f.gnt); end
            tick();
        end
        clear_inputs();
        tick();
        tick();
        $display("tb: test_max_burst done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_s     = 3'b100;
        addr_s[2] = 10'd3;
        tick();
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b100) begin errors++; $display("FAIL rmid_gnt: got %b want 100", bus_f.gnt); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus_f.gnt !== 3'b000) begin errors++; $display("FAIL rmid_async_gnt: got %b want 000", bus_f.gnt); end
        checks++; if (bus_b.gnt !== 3'b000) begin errors++; $display("FAIL rmid_async_gnt_b: got %b want 000", bus_b.gnt); end
        checks++; if (bus_f.rd_valid !== 3'b000) begin errors++; $display("FAIL rmid_async_rdv: got %b want 000", bus_f.rd_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus_f.rd_valid !== 3'b000) begin errors++; $display("FAIL rmid_pending_rdv: got %b want 000", bus_f.rd_valid); end
        tick();
        rst   = 1'b0;
        req_s = 3'b110;
        tick();
        @(negedge clk);
        checks++; if (bus_f.gnt !== 3'b010) begin errors++; $display("FAIL rmid_after_gnt: got %b want 010", bus_f.gnt); end
        checks++; if (bus_b.gnt !== 3'b010) begin errors++; $display("FAIL rmid_after_gnt_b: got %b want 010", bus_b.gnt); end
        clear_inputs();
        tick();
        tick();
        $display("tb: test_reset_mid done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        int m_owner [2];
        int m_last  [2];
        int m_hold  [2];
        int m_rdtag [2];
        logic [DATA_W-1:0] m_rdq [2];
        int left [NUM_REQ];
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = NUM_REQ - 1;
            m_hold[k]  = 0;
            m_rdtag[k] = -1;
            m_rdq[k]   = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_s[i]) begin
                    if (left[i] == 0) req_s[i] = 1'b0;
                    else left[i]--;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_s[i] = 1'b1;
                    left[i]  = $urandom_range(0, 7);
                end
                wren_s[i] = 1'($urandom_range(0, 1));
                addr_s[i] = IO_ADDR_W'($urandom_range(0, 63));
                d_s[i]    = DATA_W'($urandom);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [NUM_REQ-1:0] o_gnt, o_rdv, e_gnt, e_rdv;
                logic               o_we, e_we;
                logic [IO_ADDR_W-1:0] o_addr, e_addr;
                logic [DATA_W-1:0]  o_d, o_q, e_d;
                int act, nxt, mb, o;
                mb = (k == 0) ? 0 : 4;
                if (k == 0) begin
                    o_gnt = bus_f.gnt; o_rdv = bus_f.rd_valid; o_we = bus_f.ram_wren;
                    o_addr = bus_f.ram_address; o_d = bus_f.ram_d; o_q = bus_f.q;
                end else begin
                    o_gnt = bus_b.gnt; o_rdv = bus_b.rd_valid; o_we = bus_b.ram_wren;
                    o_addr = bus_b.ram_address; o_d = bus_b.ram_d; o_q = bus_b.q;
                end
                act   = (m_owner[k] >= 0 && req_s[m_owner[k]]) ? m_owner[k] : -1;
                e_gnt = '0;
                if (m_owner[k] >= 0) e_gnt[m_owner[k]] = 1'b1;
                e_rdv = '0;
                if (m_rdtag[k] >= 0) e_rdv[m_rdtag[k]] = 1'b1;
                e_we   = (act >= 0) ? wren_s[act] : 1'b0;
                e_addr = (act >= 0) ? addr_s[act] : '0;
                e_d    = (act >= 0) ? d_s[act] : '0;
                checks++; if (o_gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt[%0d] cyc %0d: got %b want %b", k, cyc, o_gnt, e_gnt); end
                checks++; if (o_rdv !== e_rdv) begin errors++; $display("FAIL rand_rdvalid[%0d] cyc %0d: got %b want %b", k, cyc, o_rdv, e_rdv); end
                checks++; if (o_we !== e_we) begin errors++; $display("FAIL rand_wren[%0d] cyc %0d: got %b want %b", k, cyc, o_we, e_we); end
                checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL rand_addr[%0d] cyc %0d: got %0d want %0d", k, cyc, o_addr, e_addr); end
                checks++; if (o_d !== e_d) begin errors++; $display("FAIL rand_d[%0d] cyc %0d: got %h want %h", k, cyc, o_d, e_d); end
                if (m_rdtag[k] >= 0) begin
                    checks++; if (o_q !== m_rdq[k]) begin errors++; $display("FAIL rand_q[%0d] cyc %0d: got %h want %h", k, cyc, o_q, m_rdq[k]); end
                end
                if (act >= 0 && !wren_s[act]) begin
                    m_rdtag[k] = act;
                    m_rdq[k]   = (k == 0) ? mem_f[addr_s[act]] : mem_b[addr_s[act]];
                end else begin
                    m_rdtag[k] = -1;
                end
                if (m_owner[k] < 0) begin
                    m_owner[k] = rr_next(req_s, m_last[k], -1);
                    m_hold[k]  = 0;
                end else begin
                    o   = m_owner[k];
                    nxt = rr_next(req_s, o, o);
                    if (!req_s[o] || (mb > 0 && m_hold[k] >= mb - 1 && nxt >= 0)) begin
                        m_last[k]  = o;
                        m_owner[k] = nxt;
                        m_hold[k]  = 0;
                    end else begin
                        m_hold[k]++;
                    end
                end
            end
            tick();
        end
        clear_inputs();
        tick();
        $display("tb: test_random done, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        for (int i = 0; i < (1 << IO_ADDR_W); i++) begin
            mem_f[i] = init_val(i);
            mem_b[i] = init_val(i);
        end
        test_reset();
        test_first_read();
        test_back_to_back();
        test_loader_write();
        test_read_tag();
        test_max_burst();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_ram_arbiter.md
Name: io_ram_arbiter

Overview:
Arbitrates the single port of the layer input/output RAM between three requesters:
- Network sequencer (requester 0): reads inputs and writes layer results.
- Image loader (requester 1): writes the 784 input pixels.
- Result reader (requester 2): reads the 10 output-layer values.

Grants are round-robin, whole-burst and registered. Each requester gets exclusive ownership of the RAM port for as long as it holds its request. The block sits between the requesters and ram_input_output.

Parameters:
NUM_REQ, 3, number of requesters (fixed order: 0 net, 1 loader, 2 reader)
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width
MAX_BURST, 0, max granted cycles per ownership when others wait; 0 = unlimited

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Req  in  NUM_REQ  per-requester ownership request, held for whole burst
Wren  in  NUM_REQ  per-requester write enable for the current cycle
Address  in  NUM_REQ x ADDR_W  per-requester address
D  in  NUM_REQ x DATA_W  per-requester write data
Gnt  out  NUM_REQ  registered one-hot grant
RdValid  out  NUM_REQ  Q holds read data for this requester this cycle
Q  out  DATA_W  read data, shared by all requesters (Ram_Q passthrough)
Ram_Wren  out  1  to RAM Wren
Ram_Address  out  ADDR_W  to RAM Address
Ram_D  out  DATA_W  to RAM D
Ram_Q  in  DATA_W  from RAM Q, valid 1 cycle after address

Behaviour:
- Reset (async, high):
  - State IDLE; Gnt=0; RdValid=0.
  - Last-owner pointer = NUM_REQ-1, so requester 0 has first priority.
  - Hold counter = 0.
  - Reset mid-burst drops ownership immediately; no pending RdValid survives.
- States: IDLE, OWN.
  - IDLE: if any Req is high at an edge, go to OWN. Winner is the first requester with Req high, searching from Last+1 round-robin. Gnt[winner] goes high next cycle. Grant latency from IDLE is 1 cycle.
  - OWN, owner Req still high and no forced release: stay in OWN and increment the hold counter.
  - OWN, owner Req sampled low (end of cycle t):
    - Last=owner.
    - If another Req is pending, hand off directly to the next round-robin winner; its Gnt is high in t+1 (no bubble).
    - Otherwise go to IDLE with Gnt=0.
  - Forced release: MAX_BURST>0, hold counter = MAX_BURST-1 and another requester pending. Gnt is withdrawn at that edge and handed off as above. The preempted requester keeps Req high and is re-queued by round-robin.
- Access rule: an access takes place in a cycle only when Gnt[i] && Req[i].
  - Ram_Address/Ram_D/Ram_Wren are combinational muxes of the owner's inputs.
  - With no valid access: Ram_Wren=0, Ram_Address=0, Ram_D=0.
  - Writes from non-owners are never forwarded.
- Read return: RdValid[i] is registered and high in cycle t+1 iff requester i made a valid access with Wren=0 in cycle t. Q=Ram_Q. The return is tagged to the issuing requester even if ownership changed at that edge.
- Simultaneous events:
  - Several requests rising in the same cycle: round-robin order decides.
  - Owner drops Req while the only other requester raises Req in the same cycle: handoff to that requester.
- Hold counter resets to 0 on every grant change.
- Gnt is always one-hot or zero. Assert this in simulation.

Decomposition:
- Shared package (with the BRAM address constants):
  - REQ_NET=0, REQ_LOAD=1, REQ_READ=2, NUM_REQ.
  - IO_ADDR_W=10, DATA_W=16.
  - enum arb_state_t {IDLE, OWN}.
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and last index. Outputs: winner index and any_valid.

Test Plan:
- Reset, then Req=3'b001 at cycle 2 -> Gnt=3'b001 from cycle 3. Read at addr 5 in cycle 3 -> Ram_Address=5, RdValid=3'b001 in cycle 4, Q=RAM[5].
- Req=3'b111 simultaneously from reset -> grants in order 0,1,2. Each owner drops Req after 4 cycles. Each handoff has zero idle cycles.
- Loader owns and writes D=16'h00FF to addr 20. Reader asserts Req mid-burst -> no reader access forwarded until loader drops Req. RAM[20]=16'h00FF.
- Owner 0 issues a read in its last cycle while handing off to 2 -> RdValid=3'b001 (not 3'b100) next cycle.
- MAX_BURST=4, net holds Req and loader requests -> Gnt[0] drops after 4 granted cycles and Gnt[1] rises. After loader releases, Gnt[0] returns.
- Reset pulsed while the reader owns -> Gnt=0 and RdValid=0 immediately. After reset, Req=3'b110 -> requester 1 granted first.
